// File: rtl/branch_predict_fd.sv
// F/D-stage branch predictor: a direct-mapped table of saturating counters, looked up in F
// and resolved in D. Define BP_STATS_EN to build the resolved-branch and mispredict counters.
module branch_predict_fd #(
    parameter int unsigned IDX_BITS = 6,
    parameter int unsigned CNT_BITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_f,
    input  logic        br_f,
    output logic        pred_taken_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        is_branch_d,
    input  logic        cmp_taken_d,
    output logic        mispredict_d,
    output logic [31:0] branch_cnt,
    output logic [31:0] miss_cnt
);

    localparam int unsigned Depth = 1 << IDX_BITS;
    localparam logic [CNT_BITS-1:0] CntMax = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CntRst = CntMax >> 1;

    logic [CNT_BITS-1:0] cnt_q [Depth];
    logic [CNT_BITS-1:0] cnt_rd_f;
    logic [CNT_BITS-1:0] cnt_rd_d;
    logic [CNT_BITS-1:0] cnt_d;

    logic [IDX_BITS-1:0] idx_f;
    logic                valid_q, valid_d;
    logic                pred_q, pred_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    logic                update;

    // Word-aligned index, untagged; the remaining PC bits are intentionally ignored.
    assign idx_f = pc_f[IDX_BITS+1:2];

    logic unused_pc;
    assign unused_pc = ^{pc_f[31:IDX_BITS+2], pc_f[1:0]};

    assign cnt_rd_f     = cnt_q[idx_f];
    assign pred_taken_f = br_f & cnt_rd_f[CNT_BITS-1];

    assign mispredict_d = valid_q & is_branch_d & (pred_q != cmp_taken_d);
    assign update       = valid_q & is_branch_d & ~stall_d;

    always_comb begin
        valid_d = valid_q;
        pred_d  = pred_q;
        idx_d   = idx_q;
        if (!stall_d) begin
            valid_d = br_f & ~flush_d;
            pred_d  = pred_taken_f;
            idx_d   = idx_f;
        end
    end

    assign cnt_rd_d = cnt_q[idx_q];

    always_comb begin
        cnt_d = cnt_rd_d;
        if (cmp_taken_d) begin
            if (cnt_rd_d != CntMax) begin
                cnt_d = cnt_rd_d + 1'b1;
            end
        end else begin
            if (cnt_rd_d != '0) begin
                cnt_d = cnt_rd_d - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            pred_q  <= 1'b0;
            idx_q   <= '0;
            for (int i = 0; i < Depth; i++) begin
                cnt_q[i] <= CntRst;
            end
        end else begin
            valid_q <= valid_d;
            pred_q  <= pred_d;
            idx_q   <= idx_d;
            // Same-edge F lookup already read the old value: no bypass.
            if (update) begin
                cnt_q[idx_q] <= cnt_d;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (update) begin
            if (branch_cnt_q != 32'hFFFF_FFFF) begin
                branch_cnt_d = branch_cnt_q + 32'd1;
            end
            if (mispredict_d && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign miss_cnt   = miss_cnt_q;
`else
    assign branch_cnt = '0;
    assign miss_cnt   = '0;
`endif

endmodule

// File: tb/tb_branch_predict_fd.sv
// Directed, table-driven bench for branch_predict_fd at IDX_BITS=6, CNT_BITS=2.
module tb_branch_predict_fd;

    logic        clk;
    logic        reset;
    logic [31:0] pc_f;
    logic        br_f;
    logic        pred_taken_f;
    logic        stall_d;
    logic        flush_d;
    logic        is_branch_d;
    logic        cmp_taken_d;
    logic        mispredict_d;
    logic [31:0] branch_cnt;
    logic [31:0] miss_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    branch_predict_fd #(
        .IDX_BITS(6),
        .CNT_BITS(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_f        (pc_f),
        .br_f        (br_f),
        .pred_taken_f(pred_taken_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .is_branch_d (is_branch_d),
        .cmp_taken_d (cmp_taken_d),
        .mispredict_d(mispredict_d),
        .branch_cnt  (branch_cnt),
        .miss_cnt    (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        br;
        logic        stall;
        logic        flush;
        logic        isb;
        logic        cmp;
        logic        exp_pred;
        logic        exp_mis;
        int          exp_bc;
        int          exp_mc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] pc, input logic br, input logic stall,
                       input logic flush, input logic isb, input logic cmp,
                       input logic exp_pred, input logic exp_mis,
                       input int exp_bc, input int exp_mc);
        vec_t v;
        v.pc = pc; v.br = br; v.stall = stall; v.flush = flush; v.isb = isb; v.cmp = cmp;
        v.exp_pred = exp_pred; v.exp_mis = exp_mis;
`ifdef BP_STATS_EN
        v.exp_bc = exp_bc; v.exp_mc = exp_mc;
`else
        v.exp_bc = 0; v.exp_mc = 0;
`endif
        vecs.push_back(v);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input int exp);
        tests_run++;
        if (act !== 32'(exp)) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic br, input logic stall,
                         input logic flush, input logic isb, input logic cmp);
        pc_f = pc; br_f = br; stall_d = stall; flush_d = flush;
        is_branch_d = isb; cmp_taken_d = cmp;
    endtask

    initial begin
        reset = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 0x3000 and 0x3100 alias to index 0; 0x3004 is index 1. Counters reset to 1.
        //   pc            br stl fl isb cmp  pred mis  bc mc
        add(32'h3000,      1, 0, 0, 1, 1,    0, 0,    0, 0);  // reset state, D empty
        add(32'h0000,      0, 0, 0, 1, 1,    0, 1,    0, 0);  // mispredict, cnt0 1->2
        add(32'h3000,      1, 0, 0, 1, 1,    1, 0,    1, 1);  // trained; D bubble
        add(32'h0000,      0, 0, 0, 1, 1,    0, 0,    1, 1);  // cnt0 2->3
        add(32'h3000,      1, 0, 0, 0, 0,    1, 0,    2, 1);
        add(32'h0000,      0, 0, 0, 1, 0,    0, 1,    2, 1);  // cnt0 3->2
        add(32'h3000,      1, 0, 0, 0, 0,    1, 0,    3, 2);
        add(32'h0000,      0, 0, 0, 1, 0,    0, 1,    3, 2);  // cnt0 2->1
        add(32'h3000,      1, 0, 0, 0, 0,    0, 0,    4, 3);
        add(32'h0000,      0, 0, 0, 1, 0,    0, 0,    4, 3);  // cnt0 1->0
        add(32'h3000,      1, 0, 0, 0, 0,    0, 0,    5, 3);
        add(32'h3000,      1, 0, 0, 1, 1,    0, 1,    5, 3);  // collision: old value; 0->1
        add(32'h3000,      1, 0, 0, 1, 1,    0, 1,    6, 4);  // 1->2
        add(32'h3000,      1, 0, 0, 1, 1,    1, 1,    7, 5);  // 2->3
        add(32'h3000,      1, 0, 0, 1, 1,    1, 0,    8, 6);  // stays 3
        add(32'h3100,      1, 0, 0, 1, 1,    1, 0,    9, 6);  // alias sees 3, no wrap
        add(32'h0000,      0, 0, 0, 1, 0,    0, 1,   10, 6);  // 3->2
        add(32'h3000,      1, 0, 0, 0, 0,    1, 0,   11, 7);
        add(32'h0000,      0, 0, 0, 0, 0,    0, 0,   11, 7);  // inconsistent predecode
        add(32'h3004,      1, 0, 1, 0, 0,    0, 0,   11, 7);  // flushed capture
        add(32'h3004,      1, 0, 0, 1, 0,    0, 0,   11, 7);  // bubble: no mis, no update
        add(32'h3000,      1, 1, 0, 1, 1,    1, 1,   11, 7);  // stalled, pred_d=0
        add(32'h0000,      0, 1, 1, 1, 1,    0, 1,   11, 7);  // stall beats flush
        add(32'h0000,      0, 1, 0, 1, 0,    0, 0,   11, 7);  // pred_d still 0
        add(32'h3004,      1, 0, 0, 1, 1,    0, 1,   11, 7);  // leaves D: cnt1 1->2
        add(32'h3004,      1, 0, 0, 1, 0,    1, 0,   12, 8);  // cnt1 2->1
        add(32'h3004,      1, 0, 0, 0, 0,    0, 0,   13, 8);  // one increment only
        add(32'h3000,      1, 0, 0, 0, 0,    1, 0,   13, 8);

        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].pc, vecs[i].br, vecs[i].stall, vecs[i].flush,
                  vecs[i].isb, vecs[i].cmp);
            #1;
            check1($sformatf("pred_taken_f[%0d]", i), pred_taken_f, vecs[i].exp_pred);
            check1($sformatf("mispredict_d[%0d]", i), mispredict_d, vecs[i].exp_mis);
            check32($sformatf("branch_cnt[%0d]", i), branch_cnt, vecs[i].exp_bc);
            check32($sformatf("miss_cnt[%0d]", i), miss_cnt, vecs[i].exp_mc);
        end

        // Mid-operation reset with a valid taken branch in D: reset wins over update.
        @(negedge clk);
        reset = 1'b0;
        drive(32'h3000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        drive(32'h3000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        check1("post_reset_pred", pred_taken_f, 1'b0);
        check1("post_reset_mis", mispredict_d, 1'b0);
        check32("post_reset_bc", branch_cnt, 0);
        check32("post_reset_mc", miss_cnt, 0);

        // Fresh counter (1) with reset-cleared D: one taken update makes 0x3100 predict taken.
        @(negedge clk);
        drive(32'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        check1("post_reset_resolve_mis", mispredict_d, 1'b1);
        @(negedge clk);
        drive(32'h3100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check1("post_reset_alias_pred", pred_taken_f, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/branch_predict_fd.md
# branch_predict_fd

Parametrised branch predictor spanning the F and D pipeline stages. Replaces the fixed resolve-in-D-only next-PC decision with a direct-mapped table of saturating counters: F gets a same-cycle taken/not-taken guess, D compares it against the comparator result and flags a mispredict for redirect. Sits beside the D-stage control decoder. It consumes the comparator result that the decoder already uses. It feeds the next-PC mux select in F and the flush logic.

## Interface
Parameters:
- IDX_BITS, 6, table index width; table depth is 2^IDX_BITS; legal range 1..12
- CNT_BITS, 2, saturating counter width; legal range 1..4

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low reset
- pc_f  in  32  F-stage PC
- br_f  in  1  predecode: F instruction is a conditional branch (beq/bne/blez/bgez/bgtz/bltz)
- pred_taken_f  out  1  prediction for the F instruction
- stall_d  in  1  D stage held; F→D capture and table update suppressed
- flush_d  in  1  D stage squashed; the next captured entry is a bubble
- is_branch_d  in  1  D instruction is a conditional branch (from the decoder)
- cmp_taken_d  in  1  comparator result for the D branch
- mispredict_d  out  1  D branch outcome differs from its F prediction
- branch_cnt  out  32  resolved-branch count (statistics build only)
- miss_cnt  out  32  mispredict count (statistics build only)

## Operation
- Table: 2^IDX_BITS counters, each CNT_BITS wide. Index is pc_f[IDX_BITS+1:2]; word-aligned, no tag.
- Lookup: pred_taken_f = br_f & MSB(counter[idx_f]). The lookup is combinational.
- F→D register holds valid_d, pred_d and idx_d.
  - On each edge with stall_d=0, it captures {br_f, pred_taken_f, idx_f}.
  - If flush_d=1 on that edge, valid_d is cleared instead.
  - stall_d=1 holds all three fields, and takes priority over flush_d.
- Resolve: mispredict_d = valid_d & is_branch_d & (pred_d != cmp_taken_d). This output is combinational.
- Update happens on an edge where valid_d & is_branch_d & ~stall_d.
  - counter[idx_d] increments if cmp_taken_d=1, saturating at 2^CNT_BITS-1.
  - Otherwise it decrements, saturating at 0.
  - A stalled branch therefore updates exactly once, on the cycle it leaves D.
- Inconsistent predecode: if valid_d=1 and is_branch_d=0, there is no update and mispredict_d=0.
- Read/write collision: if F reads the index being written on the same edge, F sees the pre-update value. There is no bypass.
- CNT_BITS=1 degenerates to a last-outcome predictor.

## Timing
- Reset (reset=0 at an edge):
  - every counter is set to 2^(CNT_BITS-1)-1 (weakly not-taken; 0 for CNT_BITS=1)
  - valid_d=0, pred_d=0, idx_d=0
  - branch_cnt=0, miss_cnt=0
- After reset: pred_taken_f=0 for all PCs, and mispredict_d=0.
- Reset mid-operation overrides stall, flush and update on that edge.
- pred_taken_f has 0-cycle latency from pc_f/br_f.
- mispredict_d has 0-cycle latency from cmp_taken_d/is_branch_d.
- A counter update becomes visible to lookup one cycle after the updating edge.
- Back-to-back branches on the same index:
  - the second is predicted from the un-updated counter (collision rule)
  - both updates apply sequentially

## Configuration
- BP_STATS_EN defined:
  - branch_cnt increments on every updating edge.
  - miss_cnt increments on updating edges where mispredict_d=1.
  - Both saturate at 32'hFFFF_FFFF and are cleared by reset.
- BP_STATS_EN undefined: branch_cnt and miss_cnt are tied to 0, and no counter registers are built.

## Test plan
- Reset: with reset=0 for one edge, then pc_f=0x3000, br_f=1 → pred_taken_f=0, mispredict_d=0, counts 0.
- Training, CNT_BITS=2:
  - resolve the branch at 0x3000 taken twice → a third fetch of 0x3000 gives pred_taken_f=1
  - two not-taken resolutions → 0
  - five consecutive taken resolutions leave the counter at 3, not wrapped
- Mispredict: predicted not-taken, cmp_taken_d=1 → mispredict_d=1 that cycle; miss_cnt=1, branch_cnt=1 after the edge (BP_STATS_EN).
- Stall: hold stall_d=1 for 3 cycles with a taken branch in D → counter unchanged and pred_d held; exactly one increment after stall_d drops.
- Flush and collision:
  - flush_d=1 with a branch in F → valid_d=0 next cycle, no update, no mispredict.
  - F fetching 0x3000 while D updates the same index → F gets the old prediction.
- Aliasing, IDX_BITS=6: 0x3000 and 0x3100 share an index → training one changes the prediction for the other.
